// File: rtl/grey_fp16_to_u8_packer.sv
// FP16 grey pixel -> uint8 (round-to-nearest-even, clamped), packed four per 32-bit word.
// Define GREY_SAT_COUNT_EN to add the sat_count clamp-event counter port.
module grey_fp16_to_u8_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_grey,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last
`ifdef GREY_SAT_COUNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  // Round-to-nearest-even integer part; valid only for exponents 14..22.
  function automatic logic [8:0] rne_round(input logic [4:0] e, input logic [9:0] m);
    logic [10:0] sig;
    logic [10:0] ip;
    logic        rb;
    logic        sticky;
    sig    = {1'b1, m};
    ip     = sig >> (5'd25 - e);
    rb     = sig[4'(5'd24 - e)];
    sticky = |(sig & ((11'd1 << (5'd24 - e)) - 11'd1));
    rne_round = 9'(ip) + 9'(rb & (sticky | ip[0]));
  endfunction

  function automatic logic [7:0] fp16_to_u8(input logic [15:0] x);
    logic [8:0] rnd;
    fp16_to_u8 = 8'h00;
    rnd        = 9'd0;
    if (x[14:10] == 5'd31)
      fp16_to_u8 = (x[9:0] == 10'd0 && !x[15]) ? 8'hFF : 8'h00;
    else if (x[15] || x[14:10] <= 5'd13)
      fp16_to_u8 = 8'h00;
    else if (x[14:10] >= 5'd23)
      fp16_to_u8 = 8'hFF;
    else begin
      rnd        = rne_round(x[14:10], x[9:0]);
      fp16_to_u8 = rnd[8] ? 8'hFF : rnd[7:0];
    end
  endfunction

`ifdef GREY_SAT_COUNT_EN
  function automatic logic is_sat(input logic [15:0] x);
    logic [8:0] rnd;
    is_sat = 1'b0;
    rnd    = 9'd0;
    if (x[14:10] == 5'd31)
      is_sat = 1'b1;
    else if (x[15])
      is_sat = (x[14:0] != 15'd0);
    else if (x[14:10] <= 5'd13)
      is_sat = 1'b0;
    else if (x[14:10] >= 5'd23)
      is_sat = 1'b1;
    else begin
      rnd    = rne_round(x[14:10], x[9:0]);
      is_sat = rnd[8];
    end
  endfunction
`endif

  logic        vld_p1_q, vld_p1_d;
  logic [7:0]  byte_p1_q, byte_p1_d;
  logic        last_p1_q, last_p1_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic        vld_p2_q, vld_p2_d;
  logic [31:0] data_p2_q, data_p2_d;
  logic [3:0]  keep_p2_q, keep_p2_d;
  logic        last_p2_q, last_p2_d;
  logic        completes, adv_p1, in_fire;
  logic [31:0] word;
  logic [3:0]  keep_new;

  assign completes = last_p1_q || (idx_q == 2'd3);
  assign adv_p1    = vld_p1_q && (!completes || !vld_p2_q || out_ready);
  assign in_ready  = !rst && (!vld_p1_q || adv_p1);
  assign in_fire   = in_valid && in_ready;
  assign keep_new  = 4'((5'd2 << idx_q) - 5'd1);

  always_comb begin
    vld_p1_d  = vld_p1_q;
    byte_p1_d = byte_p1_q;
    last_p1_d = last_p1_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    keep_p2_d = keep_p2_q;
    last_p2_d = last_p2_q;
    word      = {8'h00, acc_q};
    word[{idx_q, 3'b000} +: 8] = byte_p1_q;

    // Stage p0 -> p1: convert and register the incoming pixel
    if (adv_p1) vld_p1_d = 1'b0;
    if (in_fire) begin
      vld_p1_d  = 1'b1;
      byte_p1_d = fp16_to_u8(in_grey);
      last_p1_d = in_last;
    end

    // Stage p1 -> p2: accumulate, or emit a packed word
    if (vld_p2_q && out_ready) vld_p2_d = 1'b0;
    if (adv_p1) begin
      if (completes) begin
        vld_p2_d = 1'b1;
        for (int i = 0; i < 4; i++)
          data_p2_d[i*8 +: 8] = keep_new[i] ? word[i*8 +: 8] : 8'h00;
        keep_p2_d = keep_new;
        last_p2_d = last_p1_q;
        idx_d     = 2'd0;
      end else begin
        acc_d[{idx_q, 3'b000} +: 8] = byte_p1_q;
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      idx_q     <= 2'd0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= 32'd0;
      keep_p2_q <= 4'd0;
      last_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      idx_q     <= idx_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      keep_p2_q <= keep_p2_d;
      last_p2_q <= last_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    byte_p1_q <= byte_p1_d;
    last_p1_q <= last_p1_d;
    acc_q     <= acc_d;
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_keep  = keep_p2_q;
  assign out_last  = last_p2_q;

`ifdef GREY_SAT_COUNT_EN
  logic        sat_p1_q, sat_p1_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_p1_d  = sat_p1_q;
    sat_cnt_d = sat_cnt_q;
    if (in_fire) sat_p1_d = is_sat(in_grey);
    if (adv_p1 && sat_p1_q && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= 16'd0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  always_ff @(posedge clk) sat_p1_q <= sat_p1_d;

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_grey_fp16_to_u8_packer.sv
// Bench for grey_fp16_to_u8_packer: vector table, scoreboard queue and real-valued reference.
module tb_grey_fp16_to_u8_packer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [15:0] in_grey;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
`ifdef GREY_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  grey_fp16_to_u8_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_grey(in_grey),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
`ifdef GREY_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  typedef struct {logic [15:0] grey; logic last; logic [7:0] exp_byte; logic exp_sat;} vec_t;
  typedef struct {logic [31:0] data; logic [3:0] keep; logic last;} word_t;

  word_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mword;
  int          midx;
  int          ready_mode;
  int          exp_sat_cnt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  function automatic void push_byte(logic [7:0] b, logic last, logic sat);
    word_t w;
    mword[midx*8 +: 8] = b;
    if (sat) exp_sat_cnt++;
    if (midx == 3 || last) begin
      w.data = mword;
      w.keep = 4'((1 << (midx + 1)) - 1);
      w.last = last;
      exp_q.push_back(w);
      mword = 32'd0;
      midx  = 0;
    end else begin
      midx++;
    end
  endfunction

  // Independent reference: exact real value, explicit half-even rounding, clamp.
  function automatic void ref_conv(input logic [15:0] x, output logic [7:0] b, output logic sat);
    int  e, m;
    real v, f, d, r;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 31) begin
      b   = (m == 0 && !x[15]) ? 8'hFF : 8'h00;
      sat = 1'b1;
      return;
    end
    if (e == 0) begin
      v = real'(m);
      for (int k = 0; k < 24; k++) v = v / 2.0;
    end else begin
      v = real'(m + 1024);
      for (int k = e; k < 25; k++) v = v / 2.0;
      for (int k = 25; k < e; k++) v = v * 2.0;
    end
    if (x[15]) begin
      b   = 8'h00;
      sat = (v != 0.0);
      return;
    end
    f = $floor(v);
    d = v - f;
    if (d > 0.5)      r = f + 1.0;
    else if (d < 0.5) r = f;
    else              r = ((int'(f) % 2) == 0) ? f : f + 1.0;
    if (r > 255.0) begin b = 8'hFF; sat = 1'b1; end
    else begin b = 8'(int'(r)); sat = 1'b0; end
  endfunction

  task automatic set_ready();
    case (ready_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic send(input logic [15:0] g, input logic l, input logic [7:0] b, input logic s);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_grey  = g;
    in_last  = l;
    acc      = 1'b0;
    n        = 0;
    while (!acc) begin
      set_ready();
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n >= 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: pixel %h not accepted after %0d cycles", g, n);
        break;
      end
    end
    in_valid = 1'b0;
    if (acc) push_byte(b, l, s);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      set_ready();
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks stability while stalled.
  initial begin
    logic  stalled;
    word_t held, w;
    stalled = 1'b0;
    held    = '{32'd0, 4'd0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        checks++;
        if (!out_valid || out_data !== held.data || out_keep !== held.keep || out_last !== held.last) begin
          errors++;
          $display("FAIL hold: got v=%b %h/%b/%b, expected v=1 %h/%b/%b",
                   out_valid, out_data, out_keep, out_last, held.data, held.keep, held.last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h/%b/%b, expected none", out_data, out_keep, out_last);
        end else begin
          w = exp_q.pop_front();
          if (out_data !== w.data || out_keep !== w.keep || out_last !== w.last) begin
            errors++;
            $display("FAIL word: got %h keep=%b last=%b, expected %h keep=%b last=%b",
                     out_data, out_keep, out_last, w.data, w.keep, w.last);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = '{out_data, out_keep, out_last};
    end
  end

  initial begin
    vec_t        tbl[20];
    logic [15:0] g;
    logic [7:0]  b;
    logic        s, l;
    int          n;

    tbl = '{
      '{16'h3E00, 1'b0, 8'h02, 1'b0}, '{16'h4100, 1'b0, 8'h02, 1'b0},
      '{16'h5800, 1'b0, 8'h80, 1'b0}, '{16'h5BF8, 1'b0, 8'hFF, 1'b0},
      '{16'h3800, 1'b0, 8'h00, 1'b0}, '{16'h5BFC, 1'b0, 8'hFF, 1'b1},
      '{16'h5CB0, 1'b0, 8'hFF, 1'b1}, '{16'hC200, 1'b0, 8'h00, 1'b1},
      '{16'h7E00, 1'b0, 8'h00, 1'b1}, '{16'h7C00, 1'b0, 8'hFF, 1'b1},
      '{16'hFC00, 1'b0, 8'h00, 1'b1}, '{16'h8000, 1'b0, 8'h00, 1'b0},
      '{16'h5800, 1'b0, 8'h80, 1'b0}, '{16'h5800, 1'b1, 8'h80, 1'b0},
      '{16'h5800, 1'b1, 8'h80, 1'b0},
      '{16'h3A00, 1'b0, 8'h01, 1'b0}, '{16'h0001, 1'b0, 8'h00, 1'b0},
      '{16'h5BF4, 1'b0, 8'hFE, 1'b0}, '{16'h4300, 1'b0, 8'h04, 1'b0},
      '{16'h3400, 1'b1, 8'h00, 1'b0}
    };

    rst = 1'b1; in_valid = 1'b0; in_grey = 16'd0; in_last = 1'b0; out_ready = 1'b1;
    ready_mode = 0; midx = 0; mword = 32'd0; exp_sat_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_keep",  32'(out_keep),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
`ifdef GREY_SAT_COUNT_EN
    chk("rst_sat_count", 32'(sat_count), 32'd0);
`endif
    rst = 1'b0;
    idle(2);

    // Latency: word-completing pixel accepted at edge N, word visible after edge N+1.
    send(16'h3C00, 1'b0, 8'h01, 1'b0);
    send(16'h4000, 1'b0, 8'h02, 1'b0);
    send(16'h4200, 1'b0, 8'h03, 1'b0);
    send(16'h4400, 1'b0, 8'h04, 1'b0);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    idle(3);

    for (int i = 0; i < 20; i++) send(tbl[i].grey, tbl[i].last, tbl[i].exp_byte, tbl[i].exp_sat);
    idle(4);

    // Backpressure: full output register plus completing byte in S1 blocks input.
    ready_mode = 2;
    send(16'h3C00, 1'b0, 8'h01, 1'b0);
    send(16'h4000, 1'b0, 8'h02, 1'b0);
    send(16'h4200, 1'b0, 8'h03, 1'b0);
    send(16'h4400, 1'b0, 8'h04, 1'b0);
    send(16'h4500, 1'b0, 8'h05, 1'b0);
    send(16'h4600, 1'b0, 8'h06, 1'b0);
    send(16'h4700, 1'b0, 8'h07, 1'b0);
    send(16'h4800, 1'b0, 8'h08, 1'b0);
    in_valid = 1'b1; in_grey = 16'h4880; in_last = 1'b0;
    @(negedge clk);
    chk("bp_in_ready",  32'(in_ready),  32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    ready_mode = 1;
    send(16'h4880, 1'b0, 8'h09, 1'b0);
    send(16'h4900, 1'b0, 8'h0A, 1'b0);
    send(16'h4980, 1'b0, 8'h0B, 1'b0);
    send(16'h4A00, 1'b0, 8'h0C, 1'b0);

    // Reset mid-frame discards the partial word.
    ready_mode = 0;
    idle(8);
    send(16'h3C00, 1'b0, 8'h01, 1'b0);
    send(16'h4000, 1'b0, 8'h02, 1'b0);
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data",  out_data,       32'd0);
    chk("mrst_out_keep",  32'(out_keep),  32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0; midx = 0; mword = 32'd0; exp_sat_cnt = 0;
    send(16'h4200, 1'b0, 8'h03, 1'b0);
    send(16'h4400, 1'b0, 8'h04, 1'b0);
    send(16'h4500, 1'b0, 8'h05, 1'b0);
    send(16'h4600, 1'b0, 8'h06, 1'b0);
    idle(3);

    // Random stream with random output backpressure.
    ready_mode = 1;
    for (int i = 0; i < 64; i++) begin
      g[15]    = ($urandom_range(0, 7) == 0);
      g[14:10] = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(12, 23));
      g[9:0]   = 10'($urandom);
      l        = ($urandom_range(0, 9) == 0);
      ref_conv(g, b, s);
      send(g, l, b, s);
    end
    send(16'h3C00, 1'b1, 8'h01, 1'b0);

    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
`ifdef GREY_SAT_COUNT_EN
    chk("sat_count", 32'(sat_count), 32'(exp_sat_cnt));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
